// File: rtl/sbox_bank_scheduler.sv
// -----------------------------------------------------------------------------
// sbox_bank_scheduler
//   Shares a bank of NUM_SBOX forward AES S-boxes between two requesters:
//   the round datapath (SubBytes over a 128-bit state) and key expansion
//   (SubWord over a 32-bit word). A state is pushed through the bank in
//   16/NUM_SBOX chunks. Key words take the bank for a single cycle. Under
//   contention the two requesters strictly alternate. Each requester has a
//   one-entry result buffer behind a valid/ready handshake.
//
// Ports
//   clk, rst                     rising-edge clock, async active-high reset
//   st_in_valid/ready/data[127:0]   state request (byte i = bits 8i+7:8i)
//   st_out_valid/ready/data[127:0]  SubBytes result, held until taken
//   kw_in_valid/ready/data[31:0]    key-word request (byte j = bits 8j+7:8j)
//   kw_out_valid/ready/data[31:0]   SubWord result, held until taken
//   busy                            a state or key request is pending
// -----------------------------------------------------------------------------
module sbox_bank_scheduler #(
  parameter int unsigned NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_in_valid,
  output logic         st_in_ready,
  input  logic [127:0] st_in_data,
  output logic         st_out_valid,
  input  logic         st_out_ready,
  output logic [127:0] st_out_data,
  input  logic         kw_in_valid,
  output logic         kw_in_ready,
  input  logic [31:0]  kw_in_data,
  output logic         kw_out_valid,
  input  logic         kw_out_ready,
  output logic [31:0]  kw_out_data,
  output logic         busy
);

  localparam int unsigned CHUNKS = 16 / NUM_SBOX;
  localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

  generate
    if (NUM_SBOX != 4 && NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
      $error("sbox_bank_scheduler: NUM_SBOX must be 4, 8 or 16");
    end
  endgenerate

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
  endfunction

  logic [127:0]  st_in_q, st_in_d;
  logic          st_pend_q, st_pend_d;
  logic [127:0]  st_out_q, st_out_d;
  logic          st_out_valid_q, st_out_valid_d;
  logic [31:0]   kw_in_q, kw_in_d;
  logic          kw_pend_q, kw_pend_d;
  logic [31:0]   kw_out_q, kw_out_d;
  logic          kw_out_valid_q, kw_out_valid_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic          prio_state_q, prio_state_d;

  logic          grant_st, grant_kw, contended;
  logic [7:0]    lane_in  [NUM_SBOX];
  logic [7:0]    lane_out [NUM_SBOX];

  assign st_in_ready  = ~st_pend_q & (~st_out_valid_q | st_out_ready);
  assign kw_in_ready  = ~kw_pend_q & (~kw_out_valid_q | kw_out_ready);
  assign st_out_valid = st_out_valid_q;
  assign st_out_data  = st_out_q;
  assign kw_out_valid = kw_out_valid_q;
  assign kw_out_data  = kw_out_q;
  assign busy         = st_pend_q | kw_pend_q;

  // Arbitration: a contended cycle goes to key when prio_state_q=0.
  assign contended = st_pend_q & kw_pend_q;
  assign grant_kw  = kw_pend_q & (~st_pend_q | ~prio_state_q);
  assign grant_st  = st_pend_q & (~kw_pend_q |  prio_state_q);

  // Lane operand select; lanes beyond the key word idle on a key grant.
  always_comb begin
    for (int unsigned n = 0; n < NUM_SBOX; n++) begin
      if (grant_kw) begin
        lane_in[n] = (n < 4) ? kw_in_q[8*n +: 8] : 8'h00;
      end else begin
        lane_in[n] = st_in_q[8*(32'(chunk_q)*NUM_SBOX + n) +: 8];
      end
      lane_out[n] = sbox_lookup(lane_in[n]);
    end
  end

  always_comb begin
    st_in_d        = st_in_q;
    st_pend_d      = st_pend_q;
    st_out_d       = st_out_q;
    st_out_valid_d = st_out_valid_q;
    kw_in_d        = kw_in_q;
    kw_pend_d      = kw_pend_q;
    kw_out_d       = kw_out_q;
    kw_out_valid_d = kw_out_valid_q;
    chunk_d        = chunk_q;
    prio_state_d   = prio_state_q;

    if (contended) begin
      prio_state_d = ~prio_state_q;
    end

    // Take first: an accept in the same cycle relies on the buffer freeing.
    if (st_out_valid_q && st_out_ready) begin
      st_out_valid_d = 1'b0;
    end
    if (kw_out_valid_q && kw_out_ready) begin
      kw_out_valid_d = 1'b0;
    end

    if (st_in_valid && st_in_ready) begin
      st_in_d   = st_in_data;
      st_pend_d = 1'b1;
    end
    if (kw_in_valid && kw_in_ready) begin
      kw_in_d   = kw_in_data;
      kw_pend_d = 1'b1;
    end

    if (grant_st) begin
      for (int unsigned n = 0; n < NUM_SBOX; n++) begin
        st_out_d[8*(32'(chunk_q)*NUM_SBOX + n) +: 8] = lane_out[n];
      end
      if (chunk_q == LAST_CHUNK) begin
        chunk_d        = '0;
        st_pend_d      = 1'b0;
        st_out_valid_d = 1'b1;
      end else begin
        chunk_d = chunk_q + 1'b1;
      end
    end

    if (grant_kw) begin
      for (int unsigned j = 0; j < 4; j++) begin
        kw_out_d[8*j +: 8] = lane_out[j];
      end
      kw_pend_d      = 1'b0;
      kw_out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_in_q        <= '0;
      st_pend_q      <= 1'b0;
      st_out_q       <= '0;
      st_out_valid_q <= 1'b0;
      kw_in_q        <= '0;
      kw_pend_q      <= 1'b0;
      kw_out_q       <= '0;
      kw_out_valid_q <= 1'b0;
      chunk_q        <= '0;
      prio_state_q   <= 1'b0;
    end else begin
      st_in_q        <= st_in_d;
      st_pend_q      <= st_pend_d;
      st_out_q       <= st_out_d;
      st_out_valid_q <= st_out_valid_d;
      kw_in_q        <= kw_in_d;
      kw_pend_q      <= kw_pend_d;
      kw_out_q       <= kw_out_d;
      kw_out_valid_q <= kw_out_valid_d;
      chunk_q        <= chunk_d;
      prio_state_q   <= prio_state_d;
    end
  end

endmodule
